// File: rtl/spi_transfer_ctrl_pkg.sv
// Shared types and constants for the SPI transfer controller.
// The state enum, the byte width and the default SCLK half-period live here.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_t;

    localparam int BYTE_W      = 8;
    localparam int DIV_DEFAULT = 2;

    // all_1s wins over all_0s; otherwise the buffer byte goes out unchanged
    function automatic logic [BYTE_W-1:0] tx_select(
        input logic              force_ones,
        input logic              force_zeros,
        input logic [BYTE_W-1:0] data
    );
        logic [BYTE_W-1:0] result;
        if (force_ones) begin
            result = {BYTE_W{1'b1}};
        end else if (force_zeros) begin
            result = {BYTE_W{1'b0}};
        end else begin
            result = data;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: DIV clk cycles low, DIV cycles high, running only while enabled.
// rise/fall flag the clk cycle whose closing edge moves sclk up/down.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

    logic [7:0] cnt_r;
    logic       wrap_s;

    assign wrap_s = en && (cnt_r == CNT_LAST);
    assign rise   = wrap_s & ~sclk;
    assign fall   = wrap_s & sclk;

    // Half-period counter; disabling parks sclk low and restarts the phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_r <= 8'd0;
            sclk  <= 1'b0;
        end else if (wrap_s) begin
            cnt_r <= 8'd0;
            sclk  <= ~sclk;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/spi_transfer_ctrl.sv
// Mode-0 SPI master moving n_tx_end+1 bytes from a TX buffer to an RX buffer
// under one continuous chip select, with a one-shot clr_send at the end.
module spi_transfer_ctrl
    import spi_pkg::*;
#(
    parameter int N   = 5,
    parameter int DIV = DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic              cs_ctrl,
    input  logic              all_1s,
    input  logic              all_0s,
    input  logic [N:0]        n_tx_end,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              miso,
    output logic [N:0]        tx_addr,
    output logic [N:0]        rx_addr,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_we,
    output logic              clr_send,
    output logic              hold_ctrl,
    output logic [N+1:0]      n_rx_end,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy
);

    localparam logic [N:0]   IDX_ONE  = {{N{1'b0}}, 1'b1};
    localparam logic [N+1:0] RX_ONE   = {{(N+1){1'b0}}, 1'b1};
    localparam logic [2:0]   BIT_LAST = 3'(BYTE_W - 1);

    spi_state_t        state_r;
    logic [N:0]        idx_r;
    logic [N:0]        end_r;
    logic              all1_r;
    logic              all0_r;
    logic [2:0]        bit_r;
    logic [N+1:0]      rx_cnt_r;
    logic [BYTE_W-1:0] tx_sr_r;
    logic [BYTE_W-1:0] rx_sr_r;
    logic [BYTE_W-1:0] load_byte_s;
    logic              shift_en_s;
    logic              rise_s;
    logic              fall_s;

    assign tx_addr     = idx_r;
    assign shift_en_s  = (state_r == ST_SHIFT);
    assign load_byte_s = tx_select(all1_r, all0_r, tx_data);

    spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en_s),
        .sclk (sclk),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Transfer FSM with its counters, shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            end_r     <= '0;
            all1_r    <= 1'b0;
            all0_r    <= 1'b0;
            bit_r     <= 3'd0;
            rx_cnt_r  <= '0;
            tx_sr_r   <= '0;
            rx_sr_r   <= '0;
            rx_addr   <= '0;
            rx_data   <= '0;
            rx_we     <= 1'b0;
            clr_send  <= 1'b0;
            hold_ctrl <= 1'b0;
            n_rx_end  <= '0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
        end else begin
            rx_we     <= 1'b0;
            hold_ctrl <= 1'b0;
            clr_send  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    mosi <= 1'b0;
                    if (send) begin
                        end_r    <= n_tx_end;
                        all1_r   <= all_1s;
                        all0_r   <= all_0s;
                        idx_r    <= '0;
                        rx_cnt_r <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= ST_SETUP;
                    end else begin
                        cs_n <= ~cs_ctrl;
                    end
                end
                ST_SETUP: begin
                    tx_sr_r <= load_byte_s;
                    mosi    <= load_byte_s[BYTE_W-1];
                    bit_r   <= 3'd0;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (rise_s) begin
                        rx_sr_r <= {rx_sr_r[BYTE_W-2:0], miso};
                    end
                    // mosi only moves on the falling edge; the last fall closes the byte
                    if (fall_s) begin
                        if (bit_r == BIT_LAST) begin
                            mosi      <= 1'b0;
                            rx_we     <= 1'b1;
                            hold_ctrl <= 1'b1;
                            rx_addr   <= idx_r;
                            rx_data   <= rx_sr_r;
                            n_rx_end  <= rx_cnt_r + RX_ONE;
                            rx_cnt_r  <= rx_cnt_r + RX_ONE;
                            state_r   <= ST_STORE;
                        end else begin
                            bit_r   <= bit_r + 3'd1;
                            tx_sr_r <= {tx_sr_r[BYTE_W-2:0], 1'b0};
                            mosi    <= tx_sr_r[BYTE_W-2];
                        end
                    end
                end
                ST_STORE: begin
                    if (idx_r == end_r) begin
                        clr_send <= 1'b1;
                        cs_n     <= ~cs_ctrl;
                        state_r  <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_ONE;
                        state_r <= ST_SETUP;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    cs_n    <= ~cs_ctrl;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    cs_n    <= 1'b1;
                    mosi    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transfer_ctrl.sv
// Randomized self-checking bench for spi_transfer_ctrl (N=5, DIV=2) with
// miso looped back from mosi through an optional per-transfer inversion.
module tb_spi_transfer_ctrl;

    localparam int N        = 5;
    localparam int DIV      = 2;
    localparam int BYTE_CYC = 16 * DIV + 2;
    localparam int BUDGET   = 8000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         send = 1'b0;
    logic         cs_ctrl = 1'b0;
    logic         all_1s = 1'b0;
    logic         all_0s = 1'b0;
    logic         flip = 1'b0;
    logic [N:0]   n_tx_end = '0;
    logic [7:0]   tx_data;
    logic         miso;
    logic [N:0]   tx_addr;
    logic [N:0]   rx_addr;
    logic [7:0]   rx_data;
    logic         rx_we, clr_send, hold_ctrl, sclk, mosi, cs_n, busy;
    logic [N+1:0] n_rx_end;
    logic [7:0]   txbuf [0:63];

    int errors = 0;
    int checks = 0;

    // observation log filled by the monitor
    int           cyc = 0;
    int           busy_t = 0;
    bit           rise_pend = 1'b0;
    logic         sclk_prev = 1'b0;
    logic         busy_prev = 1'b0;
    int           bt_q[$];
    int           rise_q[$];
    int           wt_q[$];
    logic [N:0]   wa_q[$];
    logic [7:0]   wd_q[$];
    logic [N+1:0] wn_q[$];
    bit           mosi_q[$];
    int           clr_cnt = 0;
    int           cs_err = 0;
    int           hold_err = 0;

    assign tx_data = txbuf[tx_addr];
    assign miso    = mosi ^ flip;

    always #5 clk = ~clk;

    spi_transfer_ctrl #(.N(N), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .send(send), .cs_ctrl(cs_ctrl),
        .all_1s(all_1s), .all_0s(all_0s), .n_tx_end(n_tx_end),
        .tx_data(tx_data), .miso(miso), .tx_addr(tx_addr),
        .rx_addr(rx_addr), .rx_data(rx_data), .rx_we(rx_we),
        .clr_send(clr_send), .hold_ctrl(hold_ctrl), .n_rx_end(n_rx_end),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy)
    );

    always @(negedge clk) begin
        cyc++;
        if (busy && !busy_prev) begin
            busy_t = cyc;
            bt_q.push_back(cyc);
            rise_pend = 1'b1;
        end
        if (sclk && !sclk_prev) begin
            mosi_q.push_back(mosi);
            if (rise_pend) begin
                rise_q.push_back(cyc - busy_t);
                rise_pend = 1'b0;
            end
        end
        if (rx_we) begin
            wt_q.push_back(cyc);
            wa_q.push_back(rx_addr);
            wd_q.push_back(rx_data);
            wn_q.push_back(n_rx_end);
            if (hold_ctrl !== 1'b1) hold_err++;
        end else if (hold_ctrl !== 1'b0) begin
            hold_err++;
        end
        if (clr_send) clr_cnt++;
        if (busy && !clr_send && cs_n !== 1'b0) cs_err++;
        sclk_prev = sclk;
        busy_prev = busy;
    end

    // reference: the byte that should go out for buffer slot i
    function automatic logic [7:0] model_byte(input int i, input logic a1, input logic a0);
        if (a1) return 8'hFF;
        if (a0) return 8'h00;
        return txbuf[i];
    endfunction

    task automatic start_xfer(input int n, input logic a1, input logic a0);
        n_tx_end = (N+1)'(n);
        all_1s   = a1;
        all_0s   = a0;
        send     = 1'b1;
    endtask

    task automatic wait_done(output bit to);
        int c = 0;
        while (clr_send !== 1'b1 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        to   = (c >= BUDGET);
        send = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sclk, mosi, cs_n, busy, rx_we, clr_send, hold_ctrl} !== 7'b0010000 || n_rx_end !== '0) begin
            errors++;
            $display("FAIL reset_async: sclk=%b mosi=%b cs_n=%b busy=%b we=%b clr=%b hold=%b nrx=%0d, required 0 0 1 0 0 0 0 0",
                     sclk, mosi, cs_n, busy, rx_we, clr_send, hold_ctrl, n_rx_end);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cs_n !== 1'b1 || busy !== 1'b0 || sclk !== 1'b0 || tx_addr !== '0) begin
            errors++;
            $display("FAIL reset_idle: cs_n=%b busy=%b sclk=%b tx_addr=%0d, required 1 0 0 0", cs_n, busy, sclk, tx_addr);
        end
    endtask

    task automatic test_single_byte;
        int wb = wa_q.size(), mb = mosi_q.size(), cb = clr_cnt, bb = bt_q.size(), rb = rise_q.size();
        logic [7:0] got = '0;
        bit to;
        flip     = 1'b0;
        txbuf[0] = 8'hA5;
        start_xfer(0, 1'b0, 1'b0);
        wait_done(to);
        checks++;
        if (to || wa_q.size() != wb + 1) begin
            errors++;
            $display("FAIL single_count: timeout=%0d writes=%0d, required 0 1", to, wa_q.size() - wb);
        end else begin
            for (int i = 0; i < 8; i++) got[7-i] = (mb + i < mosi_q.size()) ? mosi_q[mb+i] : 1'b0;
            checks++;
            if (got !== 8'hA5 || mosi_q.size() != mb + 8) begin
                errors++;
                $display("FAIL single_mosi: got %h over %0d bits, required a5 over 8", got, mosi_q.size() - mb);
            end
            checks++;
            if (wd_q[wb] !== 8'hA5 || wa_q[wb] !== '0 || wn_q[wb] !== (N+2)'(1)) begin
                errors++;
                $display("FAIL single_rx: data=%h addr=%0d nrx=%0d, required a5 0 1", wd_q[wb], wa_q[wb], wn_q[wb]);
            end
            checks++;
            if (wt_q[wb] - bt_q[bb] + 1 != BYTE_CYC) begin
                errors++;
                $display("FAIL single_latency: %0d cycles setup..store, required %0d", wt_q[wb] - bt_q[bb] + 1, BYTE_CYC);
            end
            checks++;
            if (rise_q[rb] != DIV + 1) begin
                errors++;
                $display("FAIL first_rise: %0d cycles, required %0d", rise_q[rb], DIV + 1);
            end
        end
        checks++;
        if (clr_cnt - cb != 1) begin
            errors++;
            $display("FAIL single_clr: %0d pulses, required 1", clr_cnt - cb);
        end
    endtask

    task automatic test_back_to_back;
        for (int s = 0; s < 6; s++) begin
            int n, wb, mb, cb, eb, hb, bb, bad;
            logic a1, a0;
            bit to;
            if (s == 0) begin
                n = 3; a1 = 1'b0; a0 = 1'b0; flip = 1'b0;
                for (int i = 0; i < 4; i++) txbuf[i] = 8'(i + 1);
            end else begin
                n    = $urandom_range(7, 0);
                a1   = ($urandom_range(4, 0) == 0);
                a0   = ($urandom_range(4, 0) == 0);
                flip = 1'($urandom_range(1, 0));
                for (int i = 0; i < 64; i++) txbuf[i] = 8'($urandom);
            end
            wb = wa_q.size(); mb = mosi_q.size(); cb = clr_cnt;
            eb = cs_err; hb = hold_err; bb = bt_q.size();
            start_xfer(n, a1, a0);
            wait_done(to);
            checks++;
            if (to || wa_q.size() - wb != n + 1 || mosi_q.size() - mb != 8 * (n + 1)) begin
                errors++;
                $display("FAIL b2b_count s%0d: timeout=%0d writes=%0d bits=%0d, required 0 %0d %0d",
                         s, to, wa_q.size() - wb, mosi_q.size() - mb, n + 1, 8 * (n + 1));
                continue;
            end
            for (int i = 0; i <= n; i++) begin
                logic [7:0] exp_rx = model_byte(i, a1, a0) ^ {8{flip}};
                checks++;
                if (wa_q[wb+i] !== (N+1)'(i) || wd_q[wb+i] !== exp_rx || wn_q[wb+i] !== (N+2)'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b_byte s%0d i%0d: addr=%0d data=%h nrx=%0d, required %0d %h %0d",
                             s, i, wa_q[wb+i], wd_q[wb+i], wn_q[wb+i], i, exp_rx, i + 1);
                end
            end
            bad = 0;
            for (int i = 0; i < 8 * (n + 1); i++) begin
                logic [7:0] b = model_byte(i / 8, a1, a0);
                if (mosi_q[mb+i] !== b[7 - (i % 8)]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_mosi s%0d: %0d wrong bits, required 0", s, bad);
            end
            bad = (wt_q[wb] - bt_q[bb] + 1 != BYTE_CYC) ? 1 : 0;
            for (int i = 1; i <= n; i++) if (wt_q[wb+i] - wt_q[wb+i-1] != BYTE_CYC) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_timing s%0d: %0d bad byte periods, required 0", s, bad);
            end
            checks++;
            if (clr_cnt - cb != 1 || cs_err != eb || hold_err != hb) begin
                errors++;
                $display("FAIL b2b_strobes s%0d: clr=%0d cs_glitch=%0d hold_err=%0d, required 1 0 0",
                         s, clr_cnt - cb, cs_err - eb, hold_err - hb);
            end
        end
    endtask

    task automatic test_force;
        for (int s = 0; s < 2; s++) begin
            int mb = mosi_q.size(), wb = wa_q.size(), ones = 0;
            bit to;
            flip     = 1'b0;
            txbuf[0] = (s == 0) ? 8'h00 : 8'h5A;
            start_xfer(0, (s == 0), 1'b1);
            wait_done(to);
            for (int i = mb; i < mosi_q.size(); i++) ones += int'(mosi_q[i]);
            checks++;
            if (to || mosi_q.size() - mb != 8 || ones != ((s == 0) ? 8 : 0) || wa_q.size() != wb + 1) begin
                errors++;
                $display("FAIL force s%0d: timeout=%0d bits=%0d ones=%0d writes=%0d, required 0 8 %0d 1",
                         s, to, mosi_q.size() - mb, ones, wa_q.size() - wb, (s == 0) ? 8 : 0);
            end else begin
                checks++;
                if (wd_q[wb] !== ((s == 0) ? 8'hFF : 8'h00)) begin
                    errors++;
                    $display("FAIL force_rx s%0d: %h, required %h", s, wd_q[wb], (s == 0) ? 8'hFF : 8'h00);
                end
            end
        end
    endtask

    task automatic test_abort;
        int wb = wa_q.size(), mb = mosi_q.size(), cb = clr_cnt, c = 0;
        bit to;
        flip = 1'b0;
        for (int i = 0; i < 64; i++) txbuf[i] = 8'($urandom);
        start_xfer(3, 1'b0, 1'b0);
        while ((wa_q.size() < wb + 1 || mosi_q.size() < mb + 12) && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (c >= BUDGET || cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: timeout=%0d cs_n=%b sclk=%b busy=%b mosi=%b, required 0 1 0 0 0",
                     c >= BUDGET, cs_n, sclk, busy, mosi);
        end
        send = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (clr_cnt != cb || wa_q.size() != wb + 1) begin
            errors++;
            $display("FAIL abort_strobes: clr=%0d writes=%0d, required 0 1", clr_cnt - cb, wa_q.size() - wb);
        end
        wb = wa_q.size();
        start_xfer(0, 1'b0, 1'b0);
        wait_done(to);
        checks++;
        if (to || wa_q.size() != wb + 1) begin
            errors++;
            $display("FAIL restart_count: timeout=%0d writes=%0d, required 0 1", to, wa_q.size() - wb);
        end else begin
            checks++;
            if (wa_q[wb] !== '0 || wd_q[wb] !== txbuf[0] || wn_q[wb] !== (N+2)'(1)) begin
                errors++;
                $display("FAIL restart_rx: addr=%0d data=%h nrx=%0d, required 0 %h 1", wa_q[wb], wd_q[wb], wn_q[wb], txbuf[0]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int wb = wa_q.size(), cb = clr_cnt;
        bit to;
        flip     = 1'b1;
        txbuf[0] = 8'($urandom_range(254, 1));
        start_xfer(0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        n_tx_end = (N+1)'(5);
        all_1s   = 1'b1;
        wait_done(to);
        checks++;
        if (to || wa_q.size() != wb + 1 || clr_cnt - cb != 1) begin
            errors++;
            $display("FAIL ignore_count: timeout=%0d writes=%0d clr=%0d, required 0 1 1", to, wa_q.size() - wb, clr_cnt - cb);
        end else begin
            checks++;
            if (wd_q[wb] !== ~txbuf[0]) begin
                errors++;
                $display("FAIL ignore_data: %h, required %h", wd_q[wb], ~txbuf[0]);
            end
        end
        all_1s = 1'b0;
    endtask

    task automatic test_max_length;
        int wb = wa_q.size(), bad = 0;
        bit to;
        flip = 1'b0;
        for (int i = 0; i < 64; i++) txbuf[i] = 8'($urandom);
        start_xfer(63, 1'b0, 1'b0);
        wait_done(to);
        checks++;
        if (to || wa_q.size() - wb != 64) begin
            errors++;
            $display("FAIL max_count: timeout=%0d writes=%0d, required 0 64", to, wa_q.size() - wb);
        end else begin
            for (int i = 0; i < 64; i++)
                if (wa_q[wb+i] !== (N+1)'(i) || wd_q[wb+i] !== txbuf[i] || wn_q[wb+i] !== (N+2)'(i + 1)) bad++;
            checks++;
            if (bad != 0 || wn_q[wb+63] !== (N+2)'(64)) begin
                errors++;
                $display("FAIL max_data: %0d bad writes, last nrx=%0d, required 0 64", bad, wn_q[wb+63]);
            end
        end
    endtask

    task automatic test_cs_ctrl;
        int eb = cs_err;
        bit to;
        cs_ctrl = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cs_n !== 1'b0) begin
            errors++;
            $display("FAIL cs_idle_high_sel: cs_n=%b, required 0", cs_n);
        end
        start_xfer(1, 1'b0, 1'b0);
        wait_done(to);
        checks++;
        if (to || cs_err != eb || cs_n !== 1'b0) begin
            errors++;
            $display("FAIL cs_hold: timeout=%0d glitches=%0d cs_n=%b, required 0 0 0", to, cs_err - eb, cs_n);
        end
        cs_ctrl = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cs_n !== 1'b1) begin
            errors++;
            $display("FAIL cs_idle_low_sel: cs_n=%b, required 1", cs_n);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) txbuf[i] = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_force();
        test_abort();
        test_ignore_busy();
        test_max_length();
        test_cs_ctrl();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_transfer_ctrl.md
SPI_TRANSFER_CTRL -- requirements
Module: spi_transfer_ctrl

Interface
REQ-001 Parameter N, default 5, transaction index width is N+1 bits; legal range 1..11.
REQ-002 Parameter DIV, default 2, SCLK half-period in clk cycles; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 send  input  1  start request from control register bit 0.
REQ-006 cs_ctrl  input  1  idle CS level select; idle cs_n = ~cs_ctrl.
REQ-007 all_1s / all_0s  input  1 each  force transmitted byte to 0xFF / 0x00.
REQ-008 n_tx_end  input  N+1  index of last byte; transfer length = n_tx_end+1.
REQ-009 tx_data  input  8  TX buffer read data, combinational from tx_addr.
REQ-010 miso  input  1  serial data in.
REQ-011 tx_addr / rx_addr  output  N+1 each  TX read / RX write index.
REQ-012 rx_data  output  8; rx_we  output  1  RX buffer write data and one-cycle write strobe.
REQ-013 clr_send  output  1  one-cycle pulse, drives control register wr2_c.
REQ-014 hold_ctrl  output  1; n_rx_end  output  N+2  received-byte count and one-cycle load strobe.
REQ-015 sclk, mosi, cs_n  output  1 each  SPI bus; busy  output  1  high outside IDLE.

Function
REQ-016 SPI mode 0 only: sclk idles 0; mosi changes on sclk falling edge; miso sampled on sclk rising edge; MSB first.
REQ-017 States: IDLE, SETUP, SHIFT, STORE, DONE.
REQ-018 IDLE: on send==1, latch n_tx_end, all_1s, all_0s; clear index and rx count; go to SETUP next cycle.
REQ-019 SETUP (1 cycle): cs_n=0, tx_addr=index; shift register loads 0xFF if all_1s, else 0x00 if all_0s, else tx_data (all_1s has priority).
REQ-020 SHIFT: 8 bits, each bit DIV cycles sclk=0 then DIV cycles sclk=1; exactly 16*DIV cycles; mosi = shift register MSB.
REQ-021 STORE (1 cycle): rx_we=1, rx_addr=index, rx_data=assembled byte; hold_ctrl=1 with n_rx_end = bytes received so far including this byte.
REQ-022 After STORE: index==latched n_tx_end -> DONE; else index+1 and SETUP.
REQ-023 DONE (1 cycle): clr_send=1, cs_n returns to ~cs_ctrl; next state IDLE.
REQ-024 Per-byte latency 16*DIV+2 cycles; send detection to first sclk rise DIV+1 cycles.
REQ-025 cs_n held 0 continuously from SETUP of first byte through last STORE; no deassertion between bytes.
REQ-026 send, n_tx_end, all_1s, all_0s changes while busy are ignored.
REQ-027 n_tx_end = 2^(N+1)-1 transfers 2^(N+1) bytes; n_rx_end does not wrap (N+2 bits).
REQ-028 In IDLE: sclk=0, mosi=0, rx_we=hold_ctrl=clr_send=0, cs_n = ~cs_ctrl.
REQ-029 clr_send is issued exactly once per transfer; send still high in the cycle after DONE is not possible (toggle clears it), so no restart occurs.

Reset
REQ-030 rst asserted: state IDLE, counters and shift register 0, sclk=0, mosi=0, cs_n=1, all strobes 0, n_rx_end=0, independent of clk.
REQ-031 rst mid-transfer aborts immediately; no clr_send, rx_we or hold_ctrl pulse is issued for the aborted transfer.

Structure
REQ-032 Shared package spi_pkg holds the state enum, byte width constant (8) and DIV default.
REQ-033 One sub-module spi_sclk_gen: DIV counter producing sclk plus one-cycle rise/fall strobes, enabled only in SHIFT.
REQ-034 Implementation is a single FSM plus index, bit and rx counters; no clock gating, no second clock.

Verification
REQ-035 N=5, DIV=2, n_tx_end=0, tx_data=0xA5, miso loopback from mosi -> one byte, mosi 1010_0101, rx_data=0xA5, n_rx_end=1, clr_send single pulse, 34 cycles SETUP to STORE inclusive.
REQ-036 n_tx_end=3, buffer 0x01,0x02,0x03,0x04, loopback -> rx_addr 0..3 written same values, n_rx_end 1,2,3,4 with hold_ctrl, cs_n low continuously.
REQ-037 all_1s=1 and all_0s=1, tx_data=0x00 -> mosi constant 1 for 8 bits; all_0s only -> mosi constant 0.
REQ-038 rst asserted during bit 4 of byte 2 -> cs_n=1, sclk=0 asynchronously, no clr_send; next send starts fresh at index 0.
REQ-039 n_tx_end changed 0->5 while busy -> transfer ends after 1 byte; n_tx_end=63 -> 64 bytes, n_rx_end=64.
REQ-040 cs_ctrl=1 idle -> cs_n=0 in IDLE and throughout transfer; cs_ctrl=0 -> cs_n=1 in IDLE.
